// File: rtl/seg7_mmio_scan.sv
// Memory-mapped, time-multiplexed seven-segment display controller.
//
// The CPU sees a 16-byte register window at BASE_ADDR:
//   0x0 DATA  one hex nibble per digit (digit 0 = rightmost)
//   0x4 DP    decimal point per digit
//   0x8 MASK  per-digit enable (0 = digit blanked)
//   0xC CTRL  bit0 EN, bit1 LZS (leading-zero suppression)
// The scanner gives each digit a slot of SCAN_CYCLES clocks. The first BLANK_CYCLES
// clocks of every slot keep all digits dark to stop ghosting between digits.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   addr     CPU byte address (addr[1:0] ignored)
//   data     CPU write data
//   we       write strobe
//   re       read strobe
//   rdata    registered read data
//   site_en  digit select, active-low one-hot
//   num_sel  segments, active-low, bit7 = a ... bit1 = g, bit0 = dp
module seg7_mmio_scan #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_CYCLES  = 6000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [31:0]           data,
    input  logic                  we,
    input  logic                  re,
    output logic [31:0]           rdata,
    output logic [NUM_DIGITS-1:0] site_en,
    output logic [7:0]            num_sel
);

    localparam int unsigned CntW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW = 4 * NUM_DIGITS;

    // Active-low a..g in bits 7..1; bit 0 is overwritten later from DP.
    function automatic logic [7:0] hexcode(input logic [3:0] nib);
        logic [7:0] code;
        unique case (nib)
            4'h0: code = 8'h03;
            4'h1: code = 8'h9F;
            4'h2: code = 8'h25;
            4'h3: code = 8'h0D;
            4'h4: code = 8'h99;
            4'h5: code = 8'h49;
            4'h6: code = 8'h41;
            4'h7: code = 8'h1F;
            4'h8: code = 8'h01;
            4'h9: code = 8'h09;
            4'hA: code = 8'h11;
            4'hB: code = 8'hC1;
            4'hC: code = 8'h63;
            4'hD: code = 8'h85;
            4'hE: code = 8'h61;
            default: code = 8'h71;
        endcase
        return code;
    endfunction

    logic [DataW-1:0]      data_q, data_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NUM_DIGITS-1:0] site_en_q, site_en_d;
    logic [7:0]            num_sel_q, num_sel_d;

    logic                  hit;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  run_zero;
    logic [3:0]            nibble;
    logic [7:0]            seg_code;
    logic                  suppress;
    logic                  visible;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], data};

    assign hit = (addr[31:4] == BASE_ADDR[31:4]);

    // Register file write and read-back.
    always_comb begin
        data_d  = data_q;
        dp_d    = dp_q;
        mask_d  = mask_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        if (we && hit) begin
            unique case (addr[3:2])
                2'd0:    data_d = data[DataW-1:0];
                2'd1:    dp_d   = data[NUM_DIGITS-1:0];
                2'd2:    mask_d = data[NUM_DIGITS-1:0];
                default: ctrl_d = data[1:0];
            endcase
        end
        // Reads use the pre-edge contents, so a same-cycle write returns the old value.
        if (re) begin
            rdata_d = '0;
            if (hit) begin
                unique case (addr[3:2])
                    2'd0:    rdata_d[DataW-1:0]      = data_q;
                    2'd1:    rdata_d[NUM_DIGITS-1:0] = dp_q;
                    2'd2:    rdata_d[NUM_DIGITS-1:0] = mask_q;
                    default: rdata_d[1:0]            = ctrl_q;
                endcase
            end
        end
    end

    // Slot counter and digit index; parked at 0 while disabled so enable restarts at digit 0.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!ctrl_q[0]) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CntW'(SCAN_CYCLES - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        upper_zero = '0;
        run_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero & (data_q[4*i +: 4] == 4'h0);
            upper_zero[i] = run_zero;
        end
    end

    always_comb begin
        nibble    = data_q[{idx_q, 2'b00} +: 4];
        seg_code  = hexcode(nibble);
        suppress  = ctrl_q[1] && (idx_q != '0) && upper_zero[idx_q];
        visible   = ctrl_q[0] && (cnt_q >= CntW'(BLANK_CYCLES)) && mask_q[idx_q] && !suppress;
        site_en_d = '1;
        num_sel_d = 8'hFF;
        if (visible) begin
            site_en_d = ~(NUM_DIGITS'(1) << idx_q);
            num_sel_d = {seg_code[7:1], ~dp_q[idx_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            dp_q      <= '0;
            mask_q    <= '1;
            ctrl_q    <= 2'b01;
            rdata_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            site_en_q <= '1;
            num_sel_q <= 8'hFF;
        end else begin
            data_q    <= data_d;
            dp_q      <= dp_d;
            mask_q    <= mask_d;
            ctrl_q    <= ctrl_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            site_en_q <= site_en_d;
            num_sel_q <= num_sel_d;
        end
    end

    assign rdata   = rdata_q;
    assign site_en = site_en_q;
    assign num_sel = num_sel_q;

endmodule

// File: tb/tb_seg7_mmio_scan.sv
// Self-checking bench for seg7_mmio_scan (8 digits, 8-cycle slots, 2 blank cycles).
// A cycle model predicts the display outputs every clock into a queue that is compared on
// the falling edge; directed steps check read-back through a second queue plus fixed values.
module tb_seg7_mmio_scan;

    localparam int unsigned ND   = 8;
    localparam int unsigned SC   = 8;
    localparam int unsigned BC   = 2;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic [7:0]  site_en;
    logic [7:0]  num_sel;

    int n_cmp = 0;
    int n_err = 0;

    seg7_mmio_scan #(
        .NUM_DIGITS  (ND),
        .SCAN_CYCLES (SC),
        .BLANK_CYCLES(BC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .data   (data),
        .we     (we),
        .re     (re),
        .rdata  (rdata),
        .site_en(site_en),
        .num_sel(num_sel)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] site;
        logic [7:0] seg;
    } out_t;

    logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;
    logic [1:0]  m_ctrl;
    int          m_cnt;
    int          m_idx;
    bit          m_valid;
    out_t        exp_q [$];
    logic [31:0] rd_q [$];
    out_t        e_out;

    function automatic out_t model_out();
        out_t       o;
        logic [3:0] nib;
        bit         supp;
        o.site = 8'hFF;
        o.seg  = 8'hFF;
        if (m_ctrl[0] && m_cnt >= int'(BC) && m_mask[m_idx]) begin
            nib  = m_data[m_idx*4 +: 4];
            supp = m_ctrl[1] && (m_idx > 0) && ((m_data >> (m_idx * 4)) == 32'h0);
            if (!supp) begin
                o.site = ~(8'h01 << m_idx);
                o.seg  = {hex_tab[nib][7:1], ~m_dp[m_idx]};
            end
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back(out_t'(16'hFFFF));
            m_valid <= 1'b1;
            m_data  <= '0;
            m_dp    <= '0;
            m_mask  <= 8'hFF;
            m_ctrl  <= 2'b01;
            m_cnt   <= 0;
            m_idx   <= 0;
        end else if (m_valid) begin
            exp_q.push_back(model_out());
            if (we && addr[31:4] == BASE[31:4]) begin
                case (addr[3:2])
                    2'd0:    m_data <= data;
                    2'd1:    m_dp   <= data[7:0];
                    2'd2:    m_mask <= data[7:0];
                    default: m_ctrl <= data[1:0];
                endcase
            end
            if (!m_ctrl[0]) begin
                m_cnt <= 0;
                m_idx <= 0;
            end else if (m_cnt == int'(SC) - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx == int'(ND) - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_out = exp_q.pop_front();
            n_cmp++;
            assert ({site_en, num_sel} === e_out)
            else begin
                n_err++;
                $error("FAIL scan_model: observed site=%h seg=%h expected site=%h seg=%h",
                       site_en, num_sel, e_out.site, e_out.seg);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        data = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        re   = 1'b1;
        rd_q.push_back(exp);
        tick();
        re   = 1'b0;
        chk(tag, rdata, rd_q.pop_front());
    endtask

    // Wait for the first lit cycle of the given digit; a timeout counts as a failure.
    task automatic wait_start(input logic [7:0] tgt, input string tag);
        int n = 0;
        while (site_en == tgt && n < 200) begin
            tick();
            n++;
        end
        while (site_en != tgt && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {24'h0, site_en}, {24'h0, tgt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] order [$];
        logic [7:0] prev;
        logic [7:0] off_acc;

        rst  = 1'b1;
        we   = 1'b0;
        re   = 1'b0;
        addr = '0;
        data = '0;
        repeat (3) tick();
        chk("rst_site", {24'h0, site_en}, 32'hFF);
        chk("rst_seg", {24'h0, num_sel}, 32'hFF);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Two blank cycles, then digit 0 showing '0' for six cycles.
        tick();
        tick();
        chk("blank_site", {24'h0, site_en}, 32'hFF);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("first_site", {24'h0, site_en}, 32'hFE);
            chk("first_seg", {24'h0, num_sel}, 32'h03);
        end
        tick();
        chk("slot1_blank", {24'h0, site_en}, 32'hFF);

        // Hex data, scan order and period.
        wr(BASE, 32'h1234_ABCD);
        wait_start(8'hFE, "wait_d0");
        chk("d0_seg_D", {24'h0, num_sel}, 32'h85);
        order.delete();
        order.push_back(site_en);
        prev = site_en;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (site_en != 8'hFF && site_en != prev) begin
                order.push_back(site_en);
                prev = site_en;
            end
            if (site_en == 8'h7F) chk("d7_seg_1", {24'h0, num_sel}, 32'h9F);
        end
        chk("order_len", order.size(), 8);
        for (int i = 0; i < 8 && i < order.size(); i++) begin
            chk("order", {24'h0, order[i]}, {24'h0, ~(8'h01 << i)});
        end
        tick();
        chk("period64", {24'h0, site_en}, 32'hFE);

        // Decimal point on digit 0, digit 1 masked.
        wr(BASE + 32'h4, 32'h01);
        wr(BASE + 32'h8, 32'hFD);
        wait_start(8'hFE, "wait_d0_dp");
        chk("d0_seg_dp", {24'h0, num_sel}, 32'h84);
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            chk("d1_masked", {24'h0, site_en}, 32'hFF);
            tick();
        end
        tick();
        tick();
        chk("d2_site", {24'h0, site_en}, 32'hFB);
        chk("d2_seg_B", {24'h0, num_sel}, 32'hC1);

        // Leading-zero suppression.
        wr(BASE + 32'h8, 32'hFF);
        wr(BASE + 32'h4, 32'h00);
        wr(BASE + 32'hC, 32'h3);
        wr(BASE, 32'h0000_0050);
        wait_start(8'hFD, "wait_d1_lzs");
        chk("d1_seg_5", {24'h0, num_sel}, 32'h49);
        wait_start(8'hFE, "wait_d0_lzs");
        chk("d0_seg_0", {24'h0, num_sel}, 32'h03);
        off_acc = 8'h00;
        for (int i = 0; i < 64; i++) begin
            tick();
            off_acc = off_acc | ~site_en;
        end
        chk("lzs_upper_off", {24'h0, off_acc & 8'hFC}, 32'h0);

        // Read-back.
        rd("rd_data", BASE, 32'h0000_0050);
        rd("rd_mask_lowbits", BASE + 32'h9, 32'hFF);
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd("rd_ctrl", BASE + 32'hC, 32'h3);
        tick();
        chk("rd_hold", rdata, 32'h3);
        rd("rd_unmapped", BASE + 32'h10, 32'h0);
        wr(BASE + 32'h20, 32'hDEAD_BEEF);
        rd("rd_miss_write", BASE, 32'h0000_0050);
        addr = BASE + 32'h4;
        data = 32'hFFFF_FF0F;
        we   = 1'b1;
        re   = 1'b1;
        rd_q.push_back(32'h0);
        tick();
        we   = 1'b0;
        re   = 1'b0;
        chk("rd_same_cycle_old", rdata, rd_q.pop_front());
        rd("rd_dp_new", BASE + 32'h4, 32'h0F);

        // Remaining hex codes, checked by the cycle model.
        wr(BASE, 32'h6789_EF00);
        repeat (64) tick();

        // Disable mid-slot, then re-enable.
        wait_start(8'hFE, "wait_d0_en");
        chk("d0_seg_dp_zero", {24'h0, num_sel}, 32'h02);
        tick();
        tick();
        wr(BASE + 32'hC, 32'h0);
        tick();
        chk("dis_site", {24'h0, site_en}, 32'hFF);
        chk("dis_seg", {24'h0, num_sel}, 32'hFF);
        repeat (3) tick();
        wr(BASE + 32'hC, 32'h1);
        tick();
        tick();
        chk("reen_blank", {24'h0, site_en}, 32'hFF);
        tick();
        chk("reen_site", {24'h0, site_en}, 32'hFE);
        chk("reen_seg", {24'h0, num_sel}, 32'h02);

        // Reset mid-slot.
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_site", {24'h0, site_en}, 32'hFF);
        chk("mrst_seg", {24'h0, num_sel}, 32'hFF);
        chk("mrst_rdata", rdata, 32'h0);
        tick();
        tick();
        chk("mrst_blank", {24'h0, site_en}, 32'hFF);
        tick();
        chk("mrst_first_site", {24'h0, site_en}, 32'hFE);
        chk("mrst_first_seg", {24'h0, num_sel}, 32'h03);
        rd("mrst_data", BASE, 32'h0);
        rd("mrst_dp", BASE + 32'h4, 32'h0);
        rd("mrst_mask", BASE + 32'h8, 32'hFF);
        rd("mrst_ctrl", BASE + 32'hC, 32'h1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_mmio_scan.md
# seg7_mmio_scan

Parametrised, memory-mapped seven-segment display controller for the RISC-V single-cycle SoC. The CPU writes to four word registers: hex data, decimal-point mask, digit-enable mask and control. The block time-multiplexes up to eight common-anode digits. Compared with the single-register display interface, it adds:
- configurable digit count and scan period,
- inter-digit blanking (anti-ghosting),
- per-digit enable and decimal points,
- leading-zero suppression,
- CPU read-back.

## Interface
- NUM_DIGITS, 8, number of digits driven (legal 1..8)
- SCAN_CYCLES, 6000, clock cycles per digit slot (≥ BLANK_CYCLES+1)
- BLANK_CYCLES, 64, leading cycles of each slot with all digits off (≥0)
- BASE_ADDR, 32'h0000_0000, base of 16-byte register window (16-byte aligned)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr  in  32  CPU byte address
- data  in  32  CPU write data
- we  in  1  write strobe (one cycle per write)
- re  in  1  read strobe
- rdata  out  32  read data, registered
- site_en  out  NUM_DIGITS  digit select, active-low one-hot
- num_sel  out  8  segments, active-low: bit7=a … bit1=g, bit0=dp

## Operation
- Address hit: addr[31:4]==BASE_ADDR[31:4]. Offset is addr[3:2]; addr[1:0] is ignored.
- Register map:
  - 0x0 DATA: nibble i = digit i; digit 0 is rightmost, site_en[0].
  - 0x4 DP: bit i lights the dp of digit i.
  - 0x8 MASK: bit i=0 blanks digit i.
  - 0xC CTRL: bit0 EN, bit1 LZS (leading-zero suppression).
- Bits at or above NUM_DIGITS (DATA: above 4·NUM_DIGITS−1) and CTRL[31:2] are not stored and read 0.
- Reset values: DATA=0, DP=0, MASK=all ones (NUM_DIGITS bits), CTRL=1, rdata=0, site_en=all ones, num_sel=8'hFF.
- Write: on we && hit, the addressed register loads at the clock edge. we without a hit is ignored.
- Read: on re && hit, rdata loads the addressed register at the edge. re with a miss loads 0. Without re, rdata holds its value. A simultaneous we and re to the same register returns the old value.
- Scanner: cnt runs 0..SCAN_CYCLES−1. idx runs 0..NUM_DIGITS−1 and increments when cnt=SCAN_CYCLES−1, wrapping to 0.
- With EN=0: cnt and idx are held at 0 and the outputs are driven off. On the first cycle of EN=1, scanning starts from idx 0, cnt 0.
- Digit idx is visible when all of the following hold:
  - cnt ≥ BLANK_CYCLES,
  - MASK[idx]=1,
  - it is not suppressed.
- LZS: digit i is suppressed if LZS=1, i>0, and nibbles i..NUM_DIGITS−1 are all zero. Digit 0 is never suppressed.
- Visible digit: site_en = ~(1<<idx); num_sel = {hexcode(nibble idx)[7:1], ~DP[idx]}.
- Not visible: site_en all ones; num_sel 8'hFF. The slot still consumes SCAN_CYCLES so brightness stays constant.
- Hex codes (a..g, active-low, dp bit 1): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, B=C1, C=63, D=85, E=61, F=71. The dp bit is then replaced per the DP register.

## Timing
- site_en and num_sel are registered. The output after edge k reflects cnt, idx and register contents as they were before edge k, so there is one cycle of latency.
- A register write at edge k affects the outputs from edge k+1.
- rdata is valid the cycle after the re edge.
- Scan period = NUM_DIGITS·SCAN_CYCLES cycles. Each digit is lit for SCAN_CYCLES−BLANK_CYCLES cycles per period.
- BLANK_CYCLES=0: no blank gap; site_en moves directly between adjacent one-hot values.
- Reset mid-operation overrides everything. All registers, cnt and idx take their reset values at the next edge. The first lit output appears BLANK_CYCLES+1 edges after rst is deasserted.

## Test plan
Params for all scenarios: NUM_DIGITS=8, SCAN_CYCLES=8, BLANK_CYCLES=2.
- Reset: hold rst 3 cycles, release → site_en=FF and num_sel=FF; after release, 2 blank cycles, then site_en=FE and num_sel=03 for 6 cycles.
- Write DATA=0x1234ABCD at BASE_ADDR → digit 0 shows 85 (D) and digit 7 shows 9F (1); the scan order of site_en is FE, FD, …, 7F; the period is 64 cycles.
- DP=0x01, MASK=0xFD → digit 0 shows 84; site_en stays FF throughout digit 1's slot.
- CTRL=3, DATA=0x00000050 → digits 2..7 stay off; digit 1 shows 49 and digit 0 shows 03.
- Read DATA, MASK, CTRL (3) and an unmapped address (BASE+0x10) → rdata returns the stored values, then 0, each one cycle after re.
- Clear CTRL.EN mid-slot → outputs go off next cycle; re-enabling restarts at digit 0 after 2 blank cycles. Assert rst mid-slot → all registers return to their reset values.
